// File: rtl/fb_update_scheduler.sv
// Frame-buffer write sequencer: queues board-cell requests, tracks turn-panel redraws,
// and streams the selected sprite into the frame buffer one pixel per clock during vblank.
module fb_update_scheduler #(
    parameter int unsigned WIDTH      = 320,
    parameter int unsigned GRID_W     = 15,
    parameter int unsigned BOARD_X0   = 95,
    parameter int unsigned BOARD_Y0   = 24,
    parameter int unsigned CELL_SZ    = 10,
    parameter int unsigned BIG_SZ     = 34,
    parameter int unsigned TRI_X0     = 18,
    parameter int unsigned CIR_X0     = 268,
    parameter int unsigned PANEL_Y0   = 18,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        vga_CLK,
    input  logic        reset,
    input  logic        vblank,
    input  logic        cell_req,
    input  logic [7:0]  cell_pos,
    input  logic        cell_sym,
    output logic        cell_rdy,
    output logic        cell_err,
    input  logic        turn_req,
    input  logic        turn_val,
    output logic        fb_we,
    output logic [16:0] fb_addr,
    output logic [2:0]  fb_sel,
    output logic [10:0] spr_addr,
    output logic        busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [2:0] {IDLE, SELECT, CELL, PANEL_T, PANEL_C} state_t;
    state_t state, state_n;

    logic [8:0]  queue_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [8:0]  head;
    logic        full, empty, in_range, push, pop;

    logic        turn_pend, turn_v, job_val, take_turn;
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [5:0]  size, v_off, h_off;
    logic        done;

    logic        start, iss;
    logic [8:0]  start_x, iss_x;
    logic [7:0]  start_y, iss_y;
    logic [5:0]  start_size, iss_size, iss_v, iss_h;
    logic [2:0]  start_sel;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cell_rdy = !full;
    assign in_range = (cell_pos[7:4] <= 4'd9) && (cell_pos[3:0] <= 4'd9);
    assign push     = cell_req && !full && in_range;
    assign head     = queue_mem[rd_ptr[AW-1:0]];
    assign wr_ptr_n = push ? wr_ptr + PTR_ONE : wr_ptr;
    assign rd_ptr_n = pop  ? rd_ptr + PTR_ONE : rd_ptr;

    always_comb begin
        state_n    = state;
        start      = 1'b0;
        take_turn  = 1'b0;
        pop        = 1'b0;
        start_x    = '0;
        start_y    = '0;
        start_size = '0;
        start_sel  = '0;
        case (state)
            // Incoming requests count too, so SELECT follows acceptance by one cycle.
            IDLE: if (vblank && (turn_pend || !empty || push || turn_req)) state_n = SELECT;
            SELECT: begin
                if (turn_pend) begin
                    take_turn  = 1'b1;
                    start      = 1'b1;
                    state_n    = PANEL_T;
                    start_x    = 9'(TRI_X0);
                    start_y    = 8'(PANEL_Y0);
                    start_size = 6'(BIG_SZ);
                    start_sel  = turn_v ? 3'd3 : 3'd2;
                end else if (!empty) begin
                    pop        = 1'b1;
                    start      = 1'b1;
                    state_n    = CELL;
                    start_x    = 9'(BOARD_X0 + GRID_W * 32'(head[8:5]));
                    start_y    = 8'(BOARD_Y0 + GRID_W * 32'(head[4:1]));
                    start_size = 6'(CELL_SZ);
                    start_sel  = {2'b00, head[0]};
                end else begin
                    state_n = IDLE;
                end
            end
            // The circle panel starts in the cycle the triangle panel's last pixel is shown.
            PANEL_T: if (done) begin
                start      = 1'b1;
                state_n    = PANEL_C;
                start_x    = 9'(CIR_X0);
                start_y    = 8'(PANEL_Y0);
                start_size = 6'(BIG_SZ);
                start_sel  = job_val ? 3'd4 : 3'd5;
            end
            CELL, PANEL_C: if (done) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        iss      = vblank && (start || ((state == CELL || state == PANEL_T || state == PANEL_C) && !done));
        iss_x    = start ? start_x : x0;
        iss_y    = start ? start_y : y0;
        iss_size = start ? start_size : size;
        iss_v    = start ? '0 : v_off;
        iss_h    = start ? '0 : h_off;
    end

    always_ff @(posedge vga_CLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge vga_CLK) begin
        if (push) queue_mem[wr_ptr[AW-1:0]] <= {cell_pos, cell_sym};
    end

    always_ff @(posedge vga_CLK or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            turn_pend <= 1'b0;
            turn_v    <= 1'b0;
            job_val   <= 1'b0;
            x0        <= '0;
            y0        <= '0;
            size      <= '0;
            v_off     <= '0;
            h_off     <= '0;
            done      <= 1'b0;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_sel    <= '0;
            spr_addr  <= '0;
            cell_err  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            cell_err <= cell_req && !full && !in_range;
            busy     <= (state_n != IDLE) || (wr_ptr_n != rd_ptr_n) || turn_req || (turn_pend && !take_turn);

            if (turn_req) begin
                turn_pend <= 1'b1;
                turn_v    <= turn_val;
            end else if (take_turn) begin
                turn_pend <= 1'b0;
            end
            if (take_turn) job_val <= turn_v;

            if (start) begin
                x0     <= start_x;
                y0     <= start_y;
                size   <= start_size;
                fb_sel <= start_sel;
                v_off  <= '0;
                h_off  <= '0;
                done   <= 1'b0;
            end

            fb_we <= iss;
            if (iss) begin
                fb_addr  <= 17'((32'(iss_y) + 32'(iss_v)) * WIDTH + 32'(iss_x) + 32'(iss_h));
                spr_addr <= 11'(32'(iss_v) + 32'(iss_h) * 32'(iss_size));
                if (iss_v == iss_size - 6'd1) begin
                    v_off <= '0;
                    h_off <= iss_h + 6'd1;
                    if (iss_h == iss_size - 6'd1) done <= 1'b1;
                end else begin
                    v_off <= iss_v + 6'd1;
                    h_off <= iss_h;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_update_scheduler.sv
// Bench for fb_update_scheduler: directed vectors, multi-cycle corner sequences and
// random rounds checked against a job-level model of the expected write stream.
module tb_fb_update_scheduler;

    logic        vga_CLK = 1'b0;
    logic        reset = 1'b1;
    logic        vblank = 1'b0;
    logic        cell_req = 1'b0;
    logic [7:0]  cell_pos = '0;
    logic        cell_sym = 1'b0;
    logic        turn_req = 1'b0;
    logic        turn_val = 1'b0;
    logic        cell_rdy, cell_err, fb_we, busy;
    logic [16:0] fb_addr;
    logic [2:0]  fb_sel;
    logic [10:0] spr_addr;

    fb_update_scheduler dut (
        .vga_CLK(vga_CLK), .reset(reset), .vblank(vblank),
        .cell_req(cell_req), .cell_pos(cell_pos), .cell_sym(cell_sym),
        .cell_rdy(cell_rdy), .cell_err(cell_err),
        .turn_req(turn_req), .turn_val(turn_val),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_sel(fb_sel), .spr_addr(spr_addr),
        .busy(busy)
    );

    always #5 vga_CLK = ~vga_CLK;

    typedef struct { int addr; int sel; int spr; } wr_t;
    typedef struct { logic [7:0] pos; logic sym; logic err; int first; int last; } vec_t;

    wr_t        exp_q[$];
    logic [8:0] cellq[$];
    logic       m_pend = 1'b0;
    logic       m_val = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int first_addr, last_addr, first_cyc, last_cyc, last_spr;

    always @(posedge vga_CLK) cyc <= cyc + 1;

    // Write monitor: every observed write must be the next one the model expects.
    always begin
        wr_t e;
        @(posedge vga_CLK);
        #1;
        if (fb_we) begin
            wr_cnt++;
            if (wr_cnt == 1) begin
                first_addr = int'(fb_addr);
                first_cyc  = cyc;
            end
            last_addr = int'(fb_addr);
            last_cyc  = cyc;
            last_spr  = int'(spr_addr);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%0d sel=%0d spr=%0d, required no write", fb_addr, fb_sel, spr_addr);
            end else begin
                e = exp_q.pop_front();
                if (fb_addr !== 17'(e.addr) || fb_sel !== 3'(e.sel) || spr_addr !== 11'(e.spr) || vblank !== 1'b1) begin
                    bad++;
                    $display("FAIL write: addr=%0d sel=%0d spr=%0d vblank=%0b, required addr=%0d sel=%0d spr=%0d vblank=1",
                             fb_addr, fb_sel, spr_addr, vblank, e.addr, e.sel, e.spr);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic add_job(input int x0, input int y0, input int sz, input int sel);
        for (int h = 0; h < sz; h++) begin
            for (int v = 0; v < sz; v++) begin
                wr_t w;
                w.addr = (y0 + v) * 320 + x0 + h;
                w.sel  = sel;
                w.spr  = v + h * sz;
                exp_q.push_back(w);
            end
        end
    endtask

    // Pending turn redraw goes first, then the queued cells in arrival order.
    task automatic flush_model();
        logic [8:0] c;
        if (m_pend) begin
            add_job(18, 18, 34, m_val ? 3 : 2);
            add_job(268, 18, 34, m_val ? 4 : 5);
            m_pend = 1'b0;
        end
        while (cellq.size() > 0) begin
            c = cellq.pop_front();
            add_job(95 + 15 * int'(c[8:5]), 24 + 15 * int'(c[4:1]), 10, int'(c[0]));
        end
    endtask

    task automatic push_cell(input logic [7:0] pos, input logic sym, output logic acc);
        @(negedge vga_CLK);
        cell_req = 1'b1;
        cell_pos = pos;
        cell_sym = sym;
        acc = cell_rdy;
        if (acc && pos[7:4] <= 4'd9 && pos[3:0] <= 4'd9) cellq.push_back({pos, sym});
        @(negedge vga_CLK);
        cell_req = 1'b0;
    endtask

    task automatic pulse_turn(input logic val);
        @(negedge vga_CLK);
        turn_req = 1'b1;
        turn_val = val;
        m_pend = 1'b1;
        m_val = val;
        @(negedge vga_CLK);
        turn_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input logic rnd, input string name);
        int n = 0;
        do begin
            @(negedge vga_CLK);
            if (rnd) vblank = ($urandom_range(3, 0) != 0);
            n++;
        end while (busy && n < budget);
        vblank = 1'b1;
        check({name, "_idle"}, busy, 0);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        logic acc;
        int   acc_cyc;

        vecs[0] = '{8'h23, 1'b1, 1'b0, 22205, 25094};
        vecs[1] = '{8'h00, 1'b0, 1'b0, 7775, 10664};
        vecs[2] = '{8'h99, 1'b1, 1'b0, 51110, 53999};
        vecs[3] = '{8'h90, 1'b0, 1'b0, 7910, 10799};
        vecs[4] = '{8'hA3, 1'b0, 1'b1, 0, 0};
        vecs[5] = '{8'h3A, 1'b1, 1'b1, 0, 0};

        repeat (2) @(negedge vga_CLK);
        reset = 1'b0;
        @(negedge vga_CLK);
        check("rst_we", fb_we, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_sel", fb_sel, 0);
        check("rst_spr", spr_addr, 0);
        check("rst_err", cell_err, 0);
        check("rst_busy", busy, 0);
        check("rst_rdy", cell_rdy, 1);

        // Single cell jobs, valid and rejected.
        for (int i = 0; i < 6; i++) begin
            vblank = 1'b1;
            wr_cnt = 0;
            push_cell(vecs[i].pos, vecs[i].sym, acc);
            acc_cyc = cyc;
            flush_model();
            check("cell_err", cell_err, vecs[i].err);
            wait_idle(400, 1'b0, "cell");
            check("cell_count", wr_cnt, vecs[i].err ? 0 : 100);
            if (!vecs[i].err) begin
                check("cell_first", first_addr, vecs[i].first);
                check("cell_last", last_addr, vecs[i].last);
                check("cell_latency", first_cyc, acc_cyc + 1);
                check("cell_span", last_cyc - first_cyc, 99);
            end
            check("cell_err_clear", cell_err, 0);
        end

        // Turn update: both panels back to back.
        wr_cnt = 0;
        pulse_turn(1'b0);
        flush_model();
        wait_idle(3000, 1'b0, "turn");
        check("turn_count", wr_cnt, 2312);
        check("turn_first", first_addr, 5778);
        check("turn_last", last_addr, 16621);
        check("turn_span", last_cyc - first_cyc, 2311);

        // Priority and backpressure.
        vblank = 1'b0;
        wr_cnt = 0;
        push_cell(8'h11, 1'b0, acc);
        push_cell(8'h52, 1'b1, acc);
        push_cell(8'h87, 1'b0, acc);
        push_cell(8'h34, 1'b1, acc);
        check("prio_rdy_full", cell_rdy, 0);
        push_cell(8'h66, 1'b1, acc);
        check("prio_refused", acc, 0);
        pulse_turn(1'b0);
        check("prio_busy", busy, 1);
        check("prio_no_write", wr_cnt, 0);
        flush_model();
        vblank = 1'b1;
        wait_idle(4000, 1'b0, "prio");
        check("prio_count", wr_cnt, 2712);

        // Pause after the 40th write of a cell job.
        wr_cnt = 0;
        push_cell(8'h45, 1'b0, acc);
        flush_model();
        for (int i = 0; i < 300 && wr_cnt < 40; i++) @(negedge vga_CLK);
        vblank = 1'b0;
        check("pause_reach", wr_cnt, 40);
        repeat (50) @(negedge vga_CLK);
        check("pause_hold", wr_cnt, 40);
        vblank = 1'b1;
        for (int i = 0; i < 10 && wr_cnt < 41; i++) @(negedge vga_CLK);
        check("pause_resume_spr", last_spr, 40);
        wait_idle(400, 1'b0, "pause");
        check("pause_count", wr_cnt, 100);

        // Asynchronous reset in the middle of a panel job.
        wr_cnt = 0;
        pulse_turn(1'b1);
        flush_model();
        for (int i = 0; i < 1000 && wr_cnt < 500; i++) @(negedge vga_CLK);
        check("rstjob_reach", wr_cnt, 500);
        #2 reset = 1'b1;
        #1;
        check("rstjob_we", fb_we, 0);
        check("rstjob_addr", fb_addr, 0);
        check("rstjob_sel", fb_sel, 0);
        check("rstjob_spr", spr_addr, 0);
        check("rstjob_busy", busy, 0);
        check("rstjob_rdy", cell_rdy, 1);
        exp_q.delete();
        cellq.delete();
        m_pend = 1'b0;
        repeat (2) @(negedge vga_CLK);
        reset = 1'b0;
        wr_cnt = 0;
        repeat (100) @(negedge vga_CLK);
        check("rstjob_quiet", wr_cnt, 0);
        check("rstjob_idle", busy, 0);

        // Random rounds: requests collected during blanking-off, then drained with a ragged vblank.
        for (int r = 0; r < 4; r++) begin
            vblank = 1'b0;
            for (int k = 0; k < 7; k++) begin
                if ($urandom_range(3, 0) == 0)
                    pulse_turn(1'($urandom_range(1, 0)));
                else
                    push_cell({4'($urandom_range(10, 0)), 4'($urandom_range(10, 0))}, 1'($urandom_range(1, 0)), acc);
            end
            flush_model();
            wr_cnt = 0;
            wait_idle(12000, 1'b1, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_update_scheduler.md
# fb_update_scheduler

Sequences all writes into the 320x240 RGB444 interface frame buffer used by the VGA renderer. It accepts board-cell placement requests and turn-indicator updates from the game controller and queues the cell requests. It arbitrates between the two request types and streams the selected sprite into the frame buffer one pixel per clock, only during vertical blanking, so the displayed frame never tears.

## Interface
- WIDTH, 320: frame-buffer row pitch in pixels.
- GRID_W, 15: board cell pitch in pixels.
- BOARD_X0, 95 / BOARD_Y0, 24: top-left corner of cell (0,0).
- CELL_SZ, 10: small sprite edge.
- BIG_SZ, 34: turn-panel sprite edge.
- TRI_X0, 18 / CIR_X0, 268 / PANEL_Y0, 18: top-left corners of the triangle and circle panels.
- FIFO_DEPTH, 4: cell request queue depth (power of two).

Ports:
- vga_CLK  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high.
- vblank  in  1  high while frame-buffer writes are permitted.
- cell_req  in  1  valid for a cell placement.
- cell_pos  in  8  [7:4]=row, [3:0]=column.
- cell_sym  in  1  0=triangle, 1=circle.
- cell_rdy  out  1  queue can accept; transfer when cell_req&&cell_rdy.
- cell_err  out  1  one-cycle pulse: request rejected (row or column >9).
- turn_req  in  1  one-cycle pulse: redraw the turn panels.
- turn_val  in  1  0=triangle to move, 1=circle to move.
- fb_we  out  1  frame-buffer write strobe.
- fb_addr  out  17  frame-buffer pixel address.
- fb_sel  out  3  sprite ROM select: 0 filled_tri, 1 filled_cir, 2 filled_tri_big, 3 empty_tri_big, 4 filled_cir_big, 5 empty_cir_big.
- spr_addr  out  11  sprite ROM address.
- busy  out  1  job active or work pending.

## Operation
- Cell queue:
  - FIFO of {row, col, sym}.
  - cell_rdy = !full, from registered state; a push is refused on a full cycle even if a pop happens in the same cycle.
  - Out-of-range requests (row>9 or col>9) are not queued; cell_err pulses the next cycle.
- Turn request:
  - Single pending flag plus a value register.
  - A new turn_req overwrites the value and sets the flag, including during a running turn job.
  - In that case the panels are redrawn again after the current job.
- FSM: IDLE -> SELECT -> CELL or PANEL_T -> PANEL_C -> IDLE. CELL returns to IDLE directly.
  - IDLE: leaves when vblank and (turn pending or FIFO non-empty).
  - SELECT: turn pending has priority over the FIFO. The turn flag clears, or the FIFO pops, in this cycle; origin and fb_sel are latched.
  - CELL origin: x0=BOARD_X0+GRID_W*row, y0=BOARD_Y0+GRID_W*col. fb_sel = sym (0 or 1). Size CELL_SZ.
  - PANEL_T: origin (TRI_X0, PANEL_Y0), size BIG_SZ. fb_sel=2 if turn_val=0, else 3.
  - PANEL_C: origin (CIR_X0, PANEL_Y0), size BIG_SZ. fb_sel=5 if turn_val=0, else 4.
- Scan order within a job:
  - Counters v_off (inner) and h_off (outer), each 0..size-1.
  - spr_addr = v_off + h_off*size, so it increments by 1 each write.
  - fb_addr = (y0+v_off)*WIDTH + x0 + h_off, computed with no truncation in 17 bits.
- Pause: while vblank=0 inside a job, fb_we=0 and all counters hold. The job resumes at the same pixel on the next vblank.
- Reset mid-job: the job is abandoned, the FIFO is emptied and the pending turn flag is cleared.

## Timing
- Reset values: fb_we=0, fb_addr=0, fb_sel=0, spr_addr=0, cell_err=0, busy=0, cell_rdy=1. State is IDLE.
- All outputs are registered except cell_rdy.
- Latency: a request accepted in cycle t, with the FSM in IDLE and vblank high, enters SELECT at t+1. The first fb_we is at t+2.
- Write cadence is one pixel per clock with no gaps while vblank is high.
  - Cell job: 100 writes.
  - Turn job: 1156 + 1156 writes; PANEL_C's first write immediately follows PANEL_T's last write.
- One cycle in IDLE/SELECT between consecutive jobs (2 cycles with no fb_we).
- busy = state!=IDLE || FIFO non-empty || turn pending.

## Test plan
- Circle cell: reset, vblank=1, cell_pos=0x23, cell_sym=1.
  - Expect 100 fb_we pulses with fb_sel=1.
  - First write: fb_addr=22205, spr_addr=0. Second write: fb_addr=22525, spr_addr=1.
  - Last write: fb_addr=25094, spr_addr=99. busy then drops.
- Turn update: turn_req with turn_val=0.
  - Expect 1156 writes, fb_sel=2, first fb_addr=5778.
  - Then 1156 writes, fb_sel=5, first fb_addr=6028, last fb_addr=6028+33*320+33=16621.
- Priority and backpressure: with vblank=0, push 4 cells. The 5th request sees cell_rdy=0; then pulse turn_req.
  - On vblank=1, the turn job runs first, followed by the 4 cells in FIFO order.
- Pause: drop vblank after the 40th write of a cell job for 50 cycles.
  - No fb_we during the pause; the 41st write has spr_addr=40 and the correct fb_addr.
- Invalid request: cell_pos=0xA3.
  - Expect a cell_err pulse, nothing queued, busy stays 0.
- Reset mid-panel job: assert reset at write 500.
  - All outputs reach reset values asynchronously; no further writes after release until a new request.
